nora_slv_master: RTL
====================

# nora_slv_master

Bus initiator for the NORA internal slave bus. Accepts read/write burst commands on a valid/ready port, issues per-beat accesses toward internal devices (GPIO/VIA, etc.) using the slave-bus signalling, and returns read data on a response stream. It sits between a command source (debug/ICD port, DMA) and the internal device decode, all in the clk6x domain.

## Interface
- ADDR_W, 4, slave register address width.
- REQ_CYCLES, 6, clk6x cycles per access (slv_req_o high time), legal 2..15.
- clk6x  in  1  48 MHz system clock.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_rwn  in  1  1 = read burst, 0 = write burst.
- cmd_addr  in  ADDR_W  start register address.
- cmd_len  in  4  beats minus one (1..16 beats).
- cmd_autoinc  in  1  1 = address +1 per beat, 0 = fixed address.
- wd_valid  in  1  write beat data offered.
- wd_ready  out  1  write beat accepted when both high.
- wd_data  in  8  write beat data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both high.
- rsp_data  out  8  read data (0x00 for write completion).
- rsp_last  out  1  final response of the command.
- busy  out  1  high whenever state is not IDLE.
- slv_addr_o  out  ADDR_W  slave register address.
- slv_datawr_o  out  8  write data.
- slv_datawr_valid_o  out  1  write data strobe.
- slv_req_o  out  1  slave select.
- slv_rwn_o  out  1  1 = read, 0 = write.
- slv_datard_i  in  8  registered read data from slave.

## Operation
- States: IDLE, WAITWD, ACCESS, CAPTURE, RESP, WDONE.
- IDLE: cmd_ready=1. On handshake latch rwn, addr, beats=cmd_len+1, autoinc; read -> ACCESS, write -> WAITWD.
- WAITWD: wd_ready=1; on handshake latch wd_data into slv_datawr_o -> ACCESS.
- ACCESS: slv_req_o=1 for exactly REQ_CYCLES cycles (counter 0..REQ_CYCLES-1); addr, rwn, datawr stable throughout. Writes: slv_datawr_valid_o=1 only in last ACCESS cycle. Exit: read -> CAPTURE; write with beats remaining -> WAITWD; last write beat -> WDONE.
- CAPTURE: req low; rsp_data <= slv_datard_i -> RESP.
- RESP: rsp_valid=1, rsp_last=1 on final beat; holds until rsp_ready. On handshake: beats remain -> ACCESS, else IDLE.
- WDONE: rsp_valid=1, rsp_data=0x00, rsp_last=1; on rsp_ready -> IDLE. Exactly one response per write command.
- Beat advance: beats-1; addr+1 mod 2^ADDR_W if autoinc (0xF wraps to 0x0 for ADDR_W=4).
- slv_rwn_o=1 and slv_datawr_valid_o=0 whenever slv_req_o=0.
- cmd_ready, wd_ready, rsp_valid are 0 outside their named states; no command accepted while busy.
- Reset (any state, incl. mid-access): next cycle IDLE, all outputs at reset values, pending command dropped, no response.
- Reset values: cmd_ready 0 during reset then 1; wd_ready 0, rsp_valid 0, rsp_data 0x00, rsp_last 0, busy 0, slv_addr_o 0, slv_datawr_o 0x00, slv_datawr_valid_o 0, slv_req_o 0, slv_rwn_o 1.

## Timing
- All bus outputs registered. cmd handshake at T: read slv_req_o high T+1..T+REQ_CYCLES, CAPTURE at T+REQ_CYCLES+1, rsp_valid from T+REQ_CYCLES+2.
- Write: wd handshake at W: slv_req_o high W+1..W+REQ_CYCLES, slv_datawr_valid_o at W+REQ_CYCLES; WDONE rsp_valid at W+REQ_CYCLES+1.
- slv_req_o low at least 1 cycle between write beats, at least 2 between read beats (more under back-pressure).
- Read burst throughput with rsp_ready tied 1: one beat per REQ_CYCLES+2 cycles.
- Back-pressure on rsp_ready or wd_valid stalls with slv_req_o low; never stretches an access.

## Test plan
- Single read addr 0x3, slave returns 0xA5, REQ_CYCLES=6 -> req high 6 cycles with addr 0x3 rwn 1, rsp_data 0xA5 rsp_last 1 at T+8.
- Write burst len=2 addr 0x0 autoinc, data 0x11,0x22,0x33 -> three accesses addr 0,1,2, datawr_valid one cycle each in last req cycle, single rsp 0x00 last 1.
- Read burst len=3 addr 0xE autoinc, rsp_ready low 5 cycles on beat 1 -> addresses E,F,0,1, req low during stall, rsp_last only on 4th.
- Write with wd_valid delayed 10 cycles, fixed addr 0x1 -> wd_ready high, req low until data, no datawr_valid outside access.
- Reset asserted in ACCESS cycle 3 -> next cycle req 0, rwn 1, busy 0, no rsp; new command accepted afterward.
- cmd_valid held during busy -> cmd_ready 0, second command accepted only in IDLE after rsp handshake.

Source files
------------

// File: rtl/nora_slv_master.sv
// nora_slv_master: burst command initiator for the NORA internal slave bus.
// Converts read/write bursts into per-beat slave accesses, returns a response stream.
module nora_slv_master #(
   parameter int ADDR_W     = 4,
   parameter int REQ_CYCLES = 6
) (
   input  logic              clk6x,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rwn,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [3:0]        cmd_len,
   input  logic              cmd_autoinc,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [7:0]        wd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic [ADDR_W-1:0] slv_addr_o,
   output logic [7:0]        slv_datawr_o,
   output logic              slv_datawr_valid_o,
   output logic              slv_req_o,
   output logic              slv_rwn_o,
   input  logic [7:0]        slv_datard_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITWD,
      S_ACCESS,
      S_CAPTURE,
      S_RESP,
      S_WDONE
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(REQ_CYCLES - 1);
   localparam logic [3:0] CNT_PRE  = 4'(REQ_CYCLES - 2);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [4:0]        beats_q, beats_d;
   logic              rwn_q, rwn_d;
   logic              autoinc_q, autoinc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        datawr_q, datawr_d;
   logic              dv_q, dv_d;
   logic              req_q, req_d;
   logic              srwn_q, srwn_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              wd_ready_q, wd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_data_q, rsp_data_d;
   logic              rsp_last_q, rsp_last_d;

   logic [ADDR_W-1:0] addr_nxt;
   logic              more_beats;

   assign addr_nxt   = autoinc_q ? addr_q + 1'b1 : addr_q;
   assign more_beats = (beats_q > 5'd1);

   // Next-state and next-output computation for the beat sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      beats_d     = beats_q;
      rwn_d       = rwn_q;
      autoinc_d   = autoinc_q;
      addr_d      = addr_q;
      datawr_d    = datawr_q;
      dv_d        = dv_q;
      req_d       = req_q;
      srwn_d      = srwn_q;
      cmd_ready_d = cmd_ready_q;
      wd_ready_d  = wd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = rsp_last_q;
      unique case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               rwn_d       = cmd_rwn;
               addr_d      = cmd_addr;
               beats_d     = 5'(cmd_len) + 5'd1;
               autoinc_d   = cmd_autoinc;
               cmd_ready_d = 1'b0;
               cnt_d       = 4'd0;
               if (cmd_rwn) begin
                  state_d = S_ACCESS;
                  req_d   = 1'b1;
                  srwn_d  = 1'b1;
               end else begin
                  state_d    = S_WAITWD;
                  wd_ready_d = 1'b1;
               end
            end
         end
         S_WAITWD: begin
            if (wd_valid && wd_ready_q) begin
               datawr_d   = wd_data;
               wd_ready_d = 1'b0;
               state_d    = S_ACCESS;
               req_d      = 1'b1;
               srwn_d     = 1'b0;
               cnt_d      = 4'd0;
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (!rwn_q && cnt_q == CNT_PRE) begin
               dv_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d  = 4'd0;
               req_d  = 1'b0;
               srwn_d = 1'b1;
               dv_d   = 1'b0;
               if (rwn_q) begin
                  state_d = S_CAPTURE;
               end else if (more_beats) begin
                  beats_d    = beats_q - 5'd1;
                  addr_d     = addr_nxt;
                  state_d    = S_WAITWD;
                  wd_ready_d = 1'b1;
               end else begin
                  state_d     = S_WDONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'h00;
                  rsp_last_d  = 1'b1;
               end
            end
         end
         S_CAPTURE: begin
            rsp_data_d  = slv_datard_i;
            rsp_valid_d = 1'b1;
            rsp_last_d  = !more_beats;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_last_d  = 1'b0;
               if (more_beats) begin
                  beats_d = beats_q - 5'd1;
                  addr_d  = addr_nxt;
                  state_d = S_ACCESS;
                  req_d   = 1'b1;
                  srwn_d  = 1'b1;
                  cnt_d   = 4'd0;
               end else begin
                  state_d     = S_IDLE;
                  cmd_ready_d = 1'b1;
               end
            end
         end
         S_WDONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_last_d  = 1'b0;
               state_d     = S_IDLE;
               cmd_ready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops any command in flight
   always_ff @(posedge clk6x) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         beats_q     <= 5'd0;
         rwn_q       <= 1'b1;
         autoinc_q   <= 1'b0;
         addr_q      <= '0;
         datawr_q    <= 8'h00;
         dv_q        <= 1'b0;
         req_q       <= 1'b0;
         srwn_q      <= 1'b1;
         cmd_ready_q <= 1'b0;
         wd_ready_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         beats_q     <= beats_d;
         rwn_q       <= rwn_d;
         autoinc_q   <= autoinc_d;
         addr_q      <= addr_d;
         datawr_q    <= datawr_d;
         dv_q        <= dv_d;
         req_q       <= req_d;
         srwn_q      <= srwn_d;
         cmd_ready_q <= cmd_ready_d;
         wd_ready_q  <= wd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
      end
   end

   assign cmd_ready          = cmd_ready_q;
   assign wd_ready           = wd_ready_q;
   assign rsp_valid          = rsp_valid_q;
   assign rsp_data           = rsp_data_q;
   assign rsp_last           = rsp_last_q;
   assign busy               = (state_q != S_IDLE);
   assign slv_addr_o         = addr_q;
   assign slv_datawr_o       = datawr_q;
   assign slv_datawr_valid_o = dv_q;
   assign slv_req_o          = req_q;
   assign slv_rwn_o          = srwn_q;

endmodule
